pc_fetch_stage: RTL and testbench

- Sequential end of the next-PC select path.
- Holds the architectural PC register and produces `pc_plus1`, which feeds the external next-PC mux.
- Registers the mux result `next_pc` as the new PC.
- Runs the instruction-memory request/ready handshake and loads the IF/ID pipeline register.
- Applies hazard-unit stalls and branch flushes; the flush is the same taken-branch signal that drives the mux select.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/ifid_reg.sv | 29 ++
 rtl/pc_fetch_stage.sv | 105 ++++++++++
 tb/tb_pc_fetch_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states and the IF/ID record consumed by decode.
package cpu_pkg;

  localparam int          ADDR_W    = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic [31:0]       instr;
  } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Hold has priority over load; with neither set it takes a bubble.
module ifid_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  hold,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '{valid: 1'b0, pc: '0, pc_plus1: '0, instr: BUBBLE_INSTR};
    end else if (hold) begin
      q <= q;
    end else if (load) begin
      q <= d;
    end else begin
      // Bubble keeps the PC fields and only kills valid and the instruction word.
      q.valid <= 1'b0;
      q.instr <= BUBBLE_INSTR;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Fetch stage: PC register, imem request/ready handshake, flush/stall handling and IF/ID load.
//
// state   | meaning
// --------+----------------------------------------------------------------
// BOOT    | first cycle after reset, no request issued
// RUN     | request at pc outstanding; accept, redirect or hold each cycle
// DISCARD | flushed while waiting; drop the old response, then go to redirect_pc
module pc_fetch_stage #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] PC_INC    = 1,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] pc_plus1,
  input  logic              flush,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              ifid_valid,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_pc_plus1,
  output logic [31:0]       ifid_instr
);
  import cpu_pkg::*;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redirect_pc;
  logic              req;
  logic              ifid_load;
  logic              ifid_hold;
  ifid_t             ifid_d;
  ifid_t             ifid_q;

  assign pc_plus1  = pc + PC_INC;
  assign imem_addr = pc;
  assign imem_req  = req;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      redirect_pc <= '0;
      req         <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
          req   <= 1'b1;
        end
        RUN: begin
          if (flush) begin
            if (imem_ready) begin
              pc <= next_pc;
            end else begin
              redirect_pc <= next_pc;
              state       <= DISCARD;
            end
          end else if (!stall && imem_ready) begin
            pc <= next_pc;
          end
        end
        DISCARD: begin
          // The in-flight read at the old pc must complete before pc may move.
          if (imem_ready) begin
            pc    <= flush ? next_pc : redirect_pc;
            state <= RUN;
          end else if (flush) begin
            redirect_pc <= next_pc;
          end
        end
        default: begin
          state <= BOOT;
          req   <= 1'b0;
        end
      endcase
    end
  end

  assign ifid_load = (state == RUN) && !flush && !stall && imem_ready;
  assign ifid_hold = (state != BOOT) && !flush && stall;
  assign ifid_d    = '{valid: 1'b1, pc: pc, pc_plus1: pc_plus1, instr: imem_rdata};

  ifid_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .load (ifid_load),
    .hold (ifid_hold),
    .d    (ifid_d),
    .q    (ifid_q)
  );

  assign ifid_valid    = ifid_q.valid;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus1 = ifid_q.pc_plus1;
  assign ifid_instr    = ifid_q.instr;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: stimulus pushes expected IF/ID contents, a monitor pops and compares.
module tb_pc_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_pc;
  logic [31:0] pc_plus1;
  logic        flush;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus1;
  logic [31:0] ifid_instr;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] pcp1;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  pc_fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .next_pc      (next_pc),
    .pc_plus1     (pc_plus1),
    .flush        (flush),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_pc_plus1(ifid_pc_plus1),
    .ifid_instr   (ifid_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected IF/ID image per clock edge that stimulus announced.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.v});
        chk("ifid_instr", ifid_instr, e.instr);
        if (e.v) begin
          chk("ifid_pc", ifid_pc, e.pc);
          chk("ifid_pc_plus1", ifid_pc_plus1, e.pcp1);
        end
      end
    end
  end

  // Called at a negedge: check the current fetch outputs, apply inputs for the
  // next edge, announce the IF/ID contents expected after it, advance to the next negedge.
  task automatic step(input logic f, input logic s, input logic r,
                      input logic [31:0] npc, input logic [31:0] rd,
                      input logic er, input logic [31:0] ea,
                      input logic ev, input logic [31:0] epc, input logic [31:0] ei);
    exp_t e;
    logic [31:0] ea_p1;
    logic [31:0] epc_p1;
    ea_p1  = ea + 32'd1;
    epc_p1 = epc + 32'd1;
    chk("imem_req", {31'd0, imem_req}, {31'd0, er});
    chk("imem_addr", imem_addr, ea);
    chk("pc_plus1", pc_plus1, ea_p1);
    flush      = f;
    stall      = s;
    imem_ready = r;
    next_pc    = npc;
    imem_rdata = rd;
    e.v     = ev;
    e.pc    = epc;
    e.pcp1  = epc_p1;
    e.instr = ei;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic reset_checks();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_ifid_pc", ifid_pc, 32'd0);
    chk("rst_ifid_pcp1", ifid_pc_plus1, 32'd0);
    chk("rst_instr", ifid_instr, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    stall      = 1'b0;
    imem_ready = 1'b0;
    next_pc    = 32'd0;
    imem_rdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset_checks();
    rst_n = 1'b1;

    //   f s r  next_pc       rdata         req addr          v  ifid_pc       instr
    step(0,0,1, 32'd1,        32'h100,      0, 32'd0,         0, 32'd0,        32'h0);   // BOOT
    step(0,0,1, 32'd1,        32'h100,      1, 32'd0,         1, 32'd0,        32'h100);
    step(0,0,1, 32'd2,        32'h101,      1, 32'd1,         1, 32'd1,        32'h101);
    step(0,0,1, 32'd3,        32'h102,      1, 32'd2,         1, 32'd2,        32'h102);
    // taken branch at pc=3 with ready: one bubble, then the target
    step(1,0,1, 32'h40,       32'h103,      1, 32'd3,         0, 32'd0,        32'h0);
    step(0,0,1, 32'h41,       32'h140,      1, 32'h40,        1, 32'h40,       32'h140);
    step(1,0,1, 32'd4,        32'h141,      1, 32'h41,        0, 32'd0,        32'h0);
    step(0,0,1, 32'd5,        32'h104,      1, 32'd4,         1, 32'd4,        32'h104);
    // stall three cycles at pc=5: returned data dropped, IF/ID holds pc=4
    step(0,1,1, 32'd6,        32'h105,      1, 32'd5,         1, 32'd4,        32'h104);
    step(0,1,1, 32'd6,        32'h105,      1, 32'd5,         1, 32'd4,        32'h104);
    step(0,1,1, 32'd6,        32'h105,      1, 32'd5,         1, 32'd4,        32'h104);
    step(0,0,1, 32'd6,        32'h105,      1, 32'd5,         1, 32'd5,        32'h105);
    step(0,0,1, 32'd7,        32'h106,      1, 32'd6,         1, 32'd6,        32'h106);
    step(0,0,1, 32'd8,        32'h107,      1, 32'd7,         1, 32'd7,        32'h107);
    // flush while waiting at pc=8; stale 0xDEAD must be dropped
    step(1,0,0, 32'h20,       32'hDEAD,     1, 32'd8,         0, 32'd0,        32'h0);
    step(0,0,0, 32'h99,       32'hDEAD,     1, 32'd8,         0, 32'd0,        32'h0);
    step(0,0,1, 32'h99,       32'hDEAD,     1, 32'd8,         0, 32'd0,        32'h0);
    step(0,0,1, 32'h21,       32'h120,      1, 32'h20,        1, 32'h20,       32'h120);
    // second flush in DISCARD overrides the first redirect
    step(1,0,0, 32'h30,       32'hDEAD,     1, 32'h21,        0, 32'd0,        32'h0);
    step(1,0,0, 32'h50,       32'hDEAD,     1, 32'h21,        0, 32'd0,        32'h0);
    step(0,0,1, 32'h99,       32'hDEAD,     1, 32'h21,        0, 32'd0,        32'h0);
    step(0,0,1, 32'h51,       32'h150,      1, 32'h50,        1, 32'h50,       32'h150);
    // flush and stall together: flush wins
    step(1,1,1, 32'h60,       32'h151,      1, 32'h51,        0, 32'd0,        32'h0);
    step(0,0,1, 32'h61,       32'h160,      1, 32'h60,        1, 32'h60,       32'h160);
    // wrap at all-ones
    step(1,0,1, 32'hFFFF_FFFF,32'h161,      1, 32'h61,        0, 32'd0,        32'h0);
    step(0,0,1, 32'd0,        32'h1FF,      1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF,32'h1FF);
    step(0,0,1, 32'd1,        32'h100,      1, 32'd0,         1, 32'd0,        32'h100);
    // enter DISCARD, then reset in the middle of it
    step(1,0,0, 32'h70,       32'hDEAD,     1, 32'd1,         0, 32'd0,        32'h0);
    chk("discard_addr", imem_addr, 32'd1);
    rst_n      = 1'b0;
    flush      = 1'b0;
    imem_ready = 1'b1;
    @(negedge clk);
    reset_checks();
    rst_n = 1'b1;
    step(0,0,1, 32'd1,        32'h100,      0, 32'd0,         0, 32'd0,        32'h0);   // BOOT
    step(0,0,1, 32'd1,        32'h100,      1, 32'd0,         1, 32'd0,        32'h100);
    step(0,0,0, 32'd2,        32'h101,      1, 32'd1,         0, 32'd0,        32'h0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
